// File: rtl/soc_pkg.sv
// soc_pkg: shared sizes, opcode/funct encodings, ALU and branch enums, instruction fields.
// Latency: n/a, this file holds only types and constants.
// Backpressure: n/a.
package soc_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int DMEM_DEPTH = 256;
  localparam int NUM_REGS   = 32;
  localparam int PC_W       = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW    = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_JR    = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000001;

  typedef enum logic {ALU_ADD, ALU_SUB} alu_op_e;

  typedef enum logic [1:0] {BR_EQ, BR_NE, BR_GTZ} br_type_e;

  // R-type view; the I-type immediate is the concatenation rd:sh:fn
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sh;
    logic [5:0] fn;
  } instr_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/soc_regfile.sv
// soc_regfile: 32x32 register file, two async read ports, one sync write port, R0 reads 0.
// Latency: reads combinational, write visible the cycle after the edge.
// Backpressure: none; caller gates wr_en.
module soc_regfile
  import soc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_dat,
  input  logic [4:0]  rd_addr_a,
  output logic [31:0] rd_dat_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_dat_b
);

  logic [31:0] register_file_memory [NUM_REGS];

  // Async clear of every register; writes to R0 are dropped so it stays zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) register_file_memory[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      register_file_memory[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat_a = (rd_addr_a == 5'd0) ? '0 : register_file_memory[rd_addr_a];
  assign rd_dat_b = (rd_addr_b == 5'd0) ? '0 : register_file_memory[rd_addr_b];

endmodule

// File: rtl/soc_rom.sv
// soc_rom: instruction ROM, combinational read of firmware_data[addr].
// Latency: zero cycles (read is combinational).
// Backpressure: none; the preload write port only acts while enable is low.
module soc_rom
  import soc_pkg::*;
(
  input  logic            clk,
  input  logic            enable,
  input  logic [PC_W-1:0] addr,
  output logic [31:0]     data,
  input  logic            load,
  input  logic [PC_W-1:0] load_addr,
  input  logic [31:0]     load_dat
);

  logic [31:0] firmware_data [IMEM_DEPTH];

  // Preload path: writable only when the ROM is taken out of its normal enabled state
  always_ff @(posedge clk) begin
    if (!enable && load) firmware_data[load_addr] <= load_dat;
  end

  assign data = firmware_data[addr];

endmodule

// File: rtl/soc_core.sv
// soc_core: single-cycle MIPS-like SoC (CPU + ROM + RAM); SOC_DBG_PORT_EN adds dbg_pc/dbg_instr.
// Latency: one instruction fetched, executed and retired per clock.
// Backpressure: enable low freezes PC, register file and RAM; resumes from the held PC.
module soc_core
  import soc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
`ifdef SOC_DBG_PORT_EN
  output logic [7:0]  dbg_pc,
  output logic [31:0] dbg_instr,
`endif
  input  logic        enable
);

  if (1) begin : processor_unpipelined
    logic [PC_W-1:0] program_counter_address;
    logic [PC_W-1:0] program_counter_address_next;
    logic [31:0]     instruction;
    instr_t          fld;
    logic [31:0]     imm_ext;
    logic [31:0]     rs_val;
    logic [31:0]     rt_val;
    alu_op_e         alu_opcode;
    logic [31:0]     alu_input_a;
    logic [31:0]     alu_input_b;
    logic [31:0]     alu_data_out;
    logic            alu_zero_flag;
    logic            alu_sign_flag;
    logic            branch_valid;
    br_type_e        branch_type;
    logic            branch_enable;
    logic            jump_valid;
    logic [PC_W-1:0] jump_dst;
    logic [31:0]     reg_file_write_data;
    logic            reg_write_enable;
    logic [4:0]      reg_write_addr;
    logic [31:0]     ram_data_write_out;
    logic [31:0]     ram_data_read;
    logic            ram_write_enable;

    soc_rom instr_mem (
      .clk       (clk),
      .enable    (1'b1),
      .addr      (program_counter_address),
      .data      (instruction),
      .load      (1'b0),
      .load_addr ('0),
      .load_dat  ('0)
    );

    assign fld     = instruction;
    assign imm_ext = sign_ext16({fld.rd, fld.sh, fld.fn});

    soc_regfile reg_files (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (reg_write_enable && enable),
      .wr_addr   (reg_write_addr),
      .wr_dat    (reg_file_write_data),
      .rd_addr_a (fld.rs),
      .rd_dat_a  (rs_val),
      .rd_addr_b (fld.rt),
      .rd_dat_b  (rt_val)
    );

    // ALU operand/operation select; kept apart from writeback so nothing loops through alu_data_out
    always_comb begin
      alu_opcode  = ALU_ADD;
      alu_input_b = rt_val;
      case (fld.op)
        OP_RTYPE:                   if (fld.fn == FN_SUB) alu_opcode = ALU_SUB;
        OP_ADDI, OP_LW, OP_SW, OP_JR: alu_input_b = imm_ext;
        OP_BEQ, OP_BNE:             alu_opcode = ALU_SUB;
        OP_BGTZ:                    alu_input_b = '0;
        default:                    alu_input_b = rt_val;
      endcase
    end

    assign alu_input_a   = rs_val;
    assign alu_data_out  = (alu_opcode == ALU_SUB) ? (alu_input_a - alu_input_b)
                                                   : (alu_input_a + alu_input_b);
    assign alu_zero_flag = (alu_data_out == 32'd0);
    assign alu_sign_flag = alu_data_out[31];

    // Writeback, store and control-transfer decode
    always_comb begin
      reg_write_enable    = 1'b0;
      reg_write_addr      = fld.rd;
      reg_file_write_data = alu_data_out;
      ram_write_enable    = 1'b0;
      branch_valid        = 1'b0;
      branch_type         = BR_EQ;
      jump_valid          = 1'b0;
      jump_dst            = imm_ext[PC_W-1:0];
      case (fld.op)
        OP_RTYPE: reg_write_enable = (fld.fn == FN_ADD) || (fld.fn == FN_SUB);
        OP_ADDI: begin
          reg_write_enable = 1'b1;
          reg_write_addr   = fld.rt;
        end
        OP_LW: begin
          reg_write_enable    = 1'b1;
          reg_write_addr      = fld.rt;
          reg_file_write_data = ram_data_read;
        end
        OP_SW:   ram_write_enable = 1'b1;
        OP_BEQ:  branch_valid = 1'b1;
        OP_BNE: begin
          branch_valid = 1'b1;
          branch_type  = BR_NE;
        end
        OP_BGTZ: begin
          branch_valid = 1'b1;
          branch_type  = BR_GTZ;
        end
        OP_J:    jump_valid = 1'b1;
        OP_JAL: begin
          jump_valid          = 1'b1;
          reg_write_enable    = 1'b1;
          reg_write_addr      = fld.rt;
          reg_file_write_data = 32'(program_counter_address);
        end
        OP_JR: begin
          jump_valid = 1'b1;
          jump_dst   = alu_data_out[PC_W-1:0];
        end
        default: reg_write_enable = 1'b0;
      endcase
    end

    // Branch condition from the ALU flags
    always_comb begin
      branch_enable = 1'b0;
      if (branch_valid) begin
        case (branch_type)
          BR_EQ:   branch_enable = alu_zero_flag;
          BR_NE:   branch_enable = !alu_zero_flag;
          BR_GTZ:  branch_enable = !alu_zero_flag && !alu_sign_flag;
          default: branch_enable = 1'b0;
        endcase
      end
    end

    assign program_counter_address_next = (branch_enable || jump_valid)
                                          ? jump_dst
                                          : program_counter_address + PC_W'(1);

    // PC advances only while enabled; wraps naturally at the top of the ROM
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) program_counter_address <= '0;
      else if (enable) program_counter_address <= program_counter_address_next;
    end

    assign ram_data_write_out = rt_val;

    if (1) begin : ram1
      logic [31:0] memory [DMEM_DEPTH];

      // Store commits at the edge; address is the low bits of the ALU result
      always_ff @(posedge clk) begin
        if (ram_write_enable && enable) memory[alu_data_out[DMEM_AW-1:0]] <= ram_data_write_out;
      end

      assign ram_data_read = memory[alu_data_out[DMEM_AW-1:0]];
    end
  end

`ifdef SOC_DBG_PORT_EN
  assign dbg_pc    = processor_unpipelined.program_counter_address;
  assign dbg_instr = processor_unpipelined.instruction;
`endif

endmodule

// File: tb/tb_soc_core.sv
// tb_soc_core: directed program tests for soc_core with hand-computed results.
// Latency: n/a.
// Backpressure: exercises enable freeze and async reset mid-run.
module tb_soc_core;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

`ifdef SOC_DBG_PORT_EN
  logic [7:0]  dbg_pc;
  logic [31:0] dbg_instr;
`endif

  soc_core dut (
    .clk       (clk),
    .reset     (reset),
`ifdef SOC_DBG_PORT_EN
    .dbg_pc    (dbg_pc),
    .dbg_instr (dbg_instr),
`endif
    .enable    (enable)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] ADDI = 6'h08, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, BNE = 6'h05;
  localparam logic [5:0] BGTZ = 6'h07, J = 6'h02, JAL = 6'h03, JR = 6'h0E;
  localparam logic [5:0] F_ADD = 6'h00, F_SUB = 6'h01;

  function automatic logic [31:0] ri(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] rr(input logic [5:0] fn, input int rd, input int rs, input int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [7:0] pc();
    return dut.processor_unpipelined.program_counter_address;
  endfunction

  function automatic logic [31:0] rf(input int i);
    return dut.processor_unpipelined.reg_files.register_file_memory[i];
  endfunction

  function automatic logic [31:0] ram(input int i);
    return dut.processor_unpipelined.ram1.memory[i];
  endfunction

  task automatic rom_w(input int a, input logic [31:0] w);
    dut.processor_unpipelined.instr_mem.firmware_data[a] <= w;
  endtask

  task automatic ram_w(input int a, input logic [31:0] w);
    dut.processor_unpipelined.ram1.memory[a] <= w;
  endtask

  // Hold the core in reset with an all-NOP ROM; caller then loads its program
  task automatic hold_reset();
    enable = 1'b0;
    reset  = 1'b0;
    for (int a = 0; a < 256; a++) rom_w(a, 32'd0);
  endtask

  task automatic go();
    #2;
    reset  = 1'b1;
    enable = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    #1 reset = 1'b0;
    #1;
    n_checks++; if (pc() !== 8'd0) $display("FAIL reset_pc got %0d want 0", pc()); else n_pass++;
    bad = 0;
    for (int i = 0; i < 32; i++) if (rf(i) !== 32'd0) bad++;
    n_checks++; if (bad != 0) $display("FAIL reset_regs nonzero=%0d want 0", bad); else n_pass++;
    enable = 1'b1;
    step(2);
    n_checks++; if (pc() !== 8'd0) $display("FAIL reset_hold_pc got %0d want 0", pc()); else n_pass++;
  endtask

  task automatic test_pc_count();
    hold_reset();
    go();
    for (int k = 1; k <= 4; k++) begin
      step(1);
      n_checks++; if (pc() !== 8'(k)) $display("FAIL pc_count got %0d want %0d", pc(), k); else n_pass++;
    end
    n_checks++; if (rf(0) !== 32'd0) $display("FAIL nop_r0 got %h want 0", rf(0)); else n_pass++;
  endtask

  task automatic test_store();
    hold_reset();
    rom_w(0, ri(ADDI, 0, 2, 1));
    rom_w(1, ri(ADDI, 0, 3, 2));
    rom_w(2, ri(SW, 2, 3, 0));
    ram_w(1, 32'd0);
    go();
    step(3);
    n_checks++; if (ram(1) !== 32'd2) $display("FAIL sw_ram1 got %h want 2", ram(1)); else n_pass++;
    n_checks++; if (rf(2) !== 32'd1) $display("FAIL addi_r2 got %h want 1", rf(2)); else n_pass++;
    n_checks++; if (rf(3) !== 32'd2) $display("FAIL addi_r3 got %h want 2", rf(3)); else n_pass++;
    n_checks++; if (pc() !== 8'd3) $display("FAIL sw_pc got %0d want 3", pc()); else n_pass++;
  endtask

  task automatic test_sub_branch();
    hold_reset();
    rom_w(0,  ri(ADDI, 0, 5, 7));
    rom_w(1,  ri(ADDI, 0, 6, 5));
    rom_w(2,  rr(F_SUB, 6, 6, 5));
    rom_w(3,  ri(BGTZ, 6, 0, 20));
    rom_w(4,  ri(BGTZ, 5, 0, 20));
    rom_w(20, ri(BEQ, 5, 5, 30));
    rom_w(30, ri(BNE, 5, 5, 40));
    rom_w(31, ri(BNE, 5, 6, 40));
    rom_w(40, ri(SW, 0, 5, 100));
    rom_w(41, ri(LW, 6, 8, 102));
    rom_w(42, rr(F_ADD, 0, 5, 5));
    rom_w(43, ri(BEQ, 8, 5, 255));
    ram_w(100, 32'd0);
    go();
    step(3);
    n_checks++; if (rf(6) !== 32'hFFFF_FFFE) $display("FAIL sub_neg got %h want fffffffe", rf(6)); else n_pass++;
    step(1);
    n_checks++; if (pc() !== 8'd4) $display("FAIL bgtz_neg got %0d want 4", pc()); else n_pass++;
    step(1);
    n_checks++; if (pc() !== 8'd20) $display("FAIL bgtz_pos got %0d want 20", pc()); else n_pass++;
    step(1);
    n_checks++; if (pc() !== 8'd30) $display("FAIL beq_taken got %0d want 30", pc()); else n_pass++;
    step(1);
    n_checks++; if (pc() !== 8'd31) $display("FAIL bne_not got %0d want 31", pc()); else n_pass++;
    step(1);
    n_checks++; if (pc() !== 8'd40) $display("FAIL bne_taken got %0d want 40", pc()); else n_pass++;
    step(1);
    n_checks++; if (ram(100) !== 32'd7) $display("FAIL sw_ram100 got %h want 7", ram(100)); else n_pass++;
    step(1);
    n_checks++; if (rf(8) !== 32'd7) $display("FAIL lw_negbase got %h want 7", rf(8)); else n_pass++;
    step(1);
    n_checks++; if (rf(0) !== 32'd0) $display("FAIL r0_write got %h want 0", rf(0)); else n_pass++;
    step(1);
    n_checks++; if (pc() !== 8'd255) $display("FAIL beq_255 got %0d want 255", pc()); else n_pass++;
    step(1);
    n_checks++; if (pc() !== 8'd0) $display("FAIL pc_wrap got %0d want 0", pc()); else n_pass++;
  endtask

  task automatic test_jal_jr();
    hold_reset();
    rom_w(6,  ri(JAL, 0, 31, 50));
    rom_w(50, ri(JR, 31, 0, 1));
    rom_w(7,  ri(ADDI, 0, 1, 510));
    rom_w(8,  ri(JR, 1, 0, 3));
    go();
    step(6);
    n_checks++; if (pc() !== 8'd6) $display("FAIL jal_at got %0d want 6", pc()); else n_pass++;
    step(1);
    n_checks++; if (pc() !== 8'd50) $display("FAIL jal_pc got %0d want 50", pc()); else n_pass++;
    n_checks++; if (rf(31) !== 32'd6) $display("FAIL jal_link got %h want 6", rf(31)); else n_pass++;
    step(1);
    n_checks++; if (pc() !== 8'd7) $display("FAIL jr_ret got %0d want 7", pc()); else n_pass++;
    step(2);
    n_checks++; if (pc() !== 8'd1) $display("FAIL jr_trunc got %0d want 1", pc()); else n_pass++;
  endtask

  task automatic test_sieve();
    int cyc;
    logic [31:0] want [5];
    want = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd0};
    hold_reset();
    rom_w(0,  ri(LW, 0, 1, 0));
    rom_w(1,  ri(ADDI, 0, 2, 2));
    rom_w(2,  ri(ADDI, 0, 3, 0));
    rom_w(3,  rr(F_SUB, 4, 1, 2));
    rom_w(4,  ri(ADDI, 4, 4, 1));
    rom_w(5,  ri(BGTZ, 4, 0, 7));
    rom_w(6,  ri(J, 0, 0, 12));
    rom_w(7,  ri(JAL, 0, 31, 50));
    rom_w(8,  ri(ADDI, 2, 2, 1));
    rom_w(9,  ri(J, 0, 0, 3));
    rom_w(50, ri(ADDI, 0, 5, 1));
    rom_w(51, rr(F_SUB, 8, 5, 3));
    rom_w(52, ri(BGTZ, 8, 0, 60));
    rom_w(53, ri(LW, 5, 6, 0));
    rom_w(54, rr(F_ADD, 7, 2, 0));
    rom_w(55, rr(F_SUB, 7, 7, 6));
    rom_w(56, ri(BGTZ, 7, 0, 55));
    rom_w(57, ri(BEQ, 7, 0, 62));
    rom_w(58, ri(ADDI, 5, 5, 1));
    rom_w(59, ri(J, 0, 0, 51));
    rom_w(60, ri(ADDI, 3, 3, 1));
    rom_w(61, ri(SW, 3, 2, 0));
    rom_w(62, ri(JR, 31, 0, 1));
    ram_w(0, 32'd10);
    for (int i = 1; i <= 5; i++) ram_w(i, 32'd0);
    go();
    cyc = 0;
    while (pc() !== 8'd12 && cyc < 3000) begin
      step(1);
      cyc++;
    end
    n_checks++; if (pc() !== 8'd12) $display("FAIL sieve_done pc=%0d want 12 after %0d cycles", pc(), cyc); else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      if (ram(i) !== want[i-1]) $display("FAIL sieve_ram%0d got %0d want %0d", i, ram(i), want[i-1]);
      else n_pass++;
    end
    n_checks++; if (rf(3) !== 32'd4) $display("FAIL sieve_count got %0d want 4", rf(3)); else n_pass++;
  endtask

  task automatic test_enable_reset();
    hold_reset();
    rom_w(0, ri(ADDI, 1, 1, 1));
    rom_w(1, ri(SW, 0, 1, 200));
    rom_w(2, ri(J, 0, 0, 0));
    ram_w(200, 32'd0);
    go();
    step(4);
    n_checks++; if (pc() !== 8'd1) $display("FAIL run_pc got %0d want 1", pc()); else n_pass++;
    n_checks++; if (rf(1) !== 32'd2) $display("FAIL run_r1 got %0d want 2", rf(1)); else n_pass++;
    enable = 1'b0;
    step(5);
    n_checks++; if (pc() !== 8'd1) $display("FAIL frz_pc got %0d want 1", pc()); else n_pass++;
    n_checks++; if (rf(1) !== 32'd2) $display("FAIL frz_r1 got %0d want 2", rf(1)); else n_pass++;
    n_checks++; if (ram(200) !== 32'd1) $display("FAIL frz_ram got %0d want 1", ram(200)); else n_pass++;
    enable = 1'b1;
    step(1);
    n_checks++; if (pc() !== 8'd2) $display("FAIL resume_pc got %0d want 2", pc()); else n_pass++;
    n_checks++; if (ram(200) !== 32'd2) $display("FAIL resume_ram got %0d want 2", ram(200)); else n_pass++;
    step(2);
    n_checks++; if (rf(1) !== 32'd3) $display("FAIL loop_r1 got %0d want 3", rf(1)); else n_pass++;
    #3 reset = 1'b0;
    #1;
    n_checks++; if (pc() !== 8'd0) $display("FAIL arst_pc got %0d want 0", pc()); else n_pass++;
    n_checks++; if (rf(1) !== 32'd0) $display("FAIL arst_r1 got %0d want 0", rf(1)); else n_pass++;
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pc_count();
    test_store();
    test_sub_branch();
    test_jal_jr();
    test_sieve();
    test_enable_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
